// File: rtl/alu_muldiv_pkg.sv
// Purpose : shared opcode encoding, M-op decode and FSM state type for the ALU/MULDIV execution unit.
// Latency : n/a (types, constants and pure functions only).
// Backpr. : n/a.
package alu_muldiv_pkg;

    // Width of the opcode enumeration; the unit's OP_W port must be at least this wide.
    localparam int OP_ENUM_W = 6;

    typedef enum logic [OP_ENUM_W-1:0] {
        OP_ADD = 6'd0, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } op_e;

    typedef enum logic {S_IDLE, S_RUN} state_e;

    // Decoded M-op: divide vs multiply, remainder vs quotient, high vs low product half,
    // and whether each operand is interpreted as signed.
    typedef struct packed {
        logic div;
        logic rem;
        logic hi;
        logic sa;
        logic sb;
    } mop_t;

    // Shift-amount width for a given data width.
    function automatic int shamt_w(input int xlen);
        return $clog2(xlen);
    endfunction

    // Iteration counter width: must hold the value XLEN itself.
    function automatic int cnt_w(input int xlen);
        return $clog2(xlen) + 1;
    endfunction

    function automatic logic is_mop(input logic [OP_ENUM_W-1:0] op);
        return (op >= OP_MUL) && (op <= OP_REMU);
    endfunction

    function automatic mop_t decode_mop(input logic [OP_ENUM_W-1:0] op);
        mop_t m;
        m = '0;
        case (op)
            OP_MUL:    begin m.sa = 1'b1; m.sb = 1'b1; end
            OP_MULH:   begin m.hi = 1'b1; m.sa = 1'b1; m.sb = 1'b1; end
            OP_MULHSU: begin m.hi = 1'b1; m.sa = 1'b1; end
            OP_MULHU:  m.hi = 1'b1;
            OP_DIV:    begin m.div = 1'b1; m.sa = 1'b1; m.sb = 1'b1; end
            OP_DIVU:   m.div = 1'b1;
            OP_REM:    begin m.div = 1'b1; m.rem = 1'b1; m.sa = 1'b1; m.sb = 1'b1; end
            OP_REMU:   begin m.div = 1'b1; m.rem = 1'b1; end
            default:   m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Purpose : radix-2 iterative multiply (shift-add) / restoring divide on operand magnitudes, sign fixed at the end.
// Latency : XLEN enabled edges after start; done is high during the cycle whose edge completes the last iteration.
// Backpr. : en=0 freezes all state; clr aborts; start is only honoured when en=1.
// Ports   : clk, rst (sync active-low), en, clr, start, kind (decoded M-op), a/b operands -> done, result.
module muldiv_iter
    import alu_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            clr,
    input  logic            start,
    input  mop_t            kind,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = cnt_w(XLEN);

    logic [CW-1:0]     cnt;
    logic              k_div, k_rem, k_hi;
    logic              neg_q;       // final result must be negated
    logic              dz_q;        // divisor was zero
    logic [XLEN-1:0]   mag_b;       // multiplicand or divisor magnitude
    // Multiply: {partial product, multiplier}; divide: {partial remainder, dividend/quotient}.
    logic [2*XLEN-1:0] p_q, p_nxt;

    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;

    assign a_neg = kind.sa & a[XLEN-1];
    assign b_neg = kind.sb & b[XLEN-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    logic [XLEN:0]   sum, rem_sh;
    logic [XLEN-1:0] diff;

    always_comb begin
        sum    = '0;
        rem_sh = '0;
        diff   = '0;
        p_nxt  = p_q;
        if (k_div) begin
            rem_sh = {p_q[2*XLEN-1:XLEN], p_q[XLEN-1]};
            // When the subtraction succeeds the difference is below the divisor, so XLEN bits suffice.
            diff   = rem_sh[XLEN-1:0] - mag_b;
            if (rem_sh >= {1'b0, mag_b})
                p_nxt = {diff, p_q[XLEN-2:0], 1'b1};
            else
                p_nxt = {rem_sh[XLEN-1:0], p_q[XLEN-2:0], 1'b0};
        end else begin
            sum   = {1'b0, p_q[2*XLEN-1:XLEN]} + ({(XLEN+1){p_q[0]}} & {1'b0, mag_b});
            p_nxt = {sum, p_q[XLEN-1:1]};
        end
    end

    // Result is formed from the post-iteration value so the last edge can register it directly.
    // Most-negative / -1 needs no special case: the magnitude quotient 2^(XLEN-1) with an
    // unnegated sign is already the most-negative pattern, and the remainder is zero.
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem;

    always_comb begin
        prod   = neg_q ? -p_nxt : p_nxt;
        quo    = neg_q ? -p_nxt[XLEN-1:0] : p_nxt[XLEN-1:0];
        rem    = neg_q ? -p_nxt[2*XLEN-1:XLEN] : p_nxt[2*XLEN-1:XLEN];
        result = '0;
        if (k_div)
            result = k_rem ? rem : (dz_q ? '1 : quo);
        else
            result = k_hi ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt   <= '0;
            k_div <= 1'b0;
            k_rem <= 1'b0;
            k_hi  <= 1'b0;
            neg_q <= 1'b0;
            dz_q  <= 1'b0;
            mag_b <= '0;
            p_q   <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            if (start) begin
                cnt   <= CW'(XLEN);
                k_div <= kind.div;
                k_rem <= kind.rem;
                k_hi  <= kind.hi;
                // Remainder follows the dividend's sign; product and quotient follow the xor.
                neg_q <= (kind.div & kind.rem) ? a_neg : (a_neg ^ b_neg);
                dz_q  <= (b == '0);
                mag_b <= b_mag;
                p_q   <= {{XLEN{1'b0}}, a_mag};
            end else if (cnt != '0) begin
                cnt <= cnt - CW'(1);
                p_q <= p_nxt;
            end
        end
    end

    assign done = (cnt == CW'(1));

endmodule

// File: rtl/alu_muldiv.sv
// Purpose : execution unit: single-cycle RV base ALU/branch/jump plus iterative M-extension ops, one result broadcast.
// Latency : base ops broadcast the cycle after accept; M-ops the cycle after accept-edge + XLEN enabled edges.
// Backpr. : in_ready low while an M-op runs; rdy=0 freezes everything; clr aborts and clears outputs.
// Ports   : clk, rst (sync active-low), rdy, clr; in_valid/in_ready/in_op/in_rob_pos/in_rs1/in_rs2/in_imm/in_pc;
//           out_valid/out_rob_pos/out_val/out_jump/out_pc.
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int ROB_POS_W = 5,
    parameter int OP_W      = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OP_W-1:0]      in_op,
    input  logic [ROB_POS_W-1:0] in_rob_pos,
    input  logic [XLEN-1:0]      in_rs1,
    input  logic [XLEN-1:0]      in_rs2,
    input  logic [XLEN-1:0]      in_imm,
    input  logic [XLEN-1:0]      in_pc,
    output logic                 out_valid,
    output logic [ROB_POS_W-1:0] out_rob_pos,
    output logic [XLEN-1:0]      out_val,
    output logic                 out_jump,
    output logic [XLEN-1:0]      out_pc
);

    localparam int SH_W = shamt_w(XLEN);

    state_e state, state_nxt;

    logic [OP_ENUM_W-1:0] op;
    logic                 op_known;   // no opcode bits beyond the enum width are set
    logic                 accept, is_m, acc_base, acc_m;

    assign op       = OP_ENUM_W'(in_op);
    assign op_known = (OP_W'(op) == in_op);
    assign in_ready = (state == S_IDLE);
    assign accept   = in_valid & in_ready & rdy & rst & ~clr;
    assign is_m     = op_known & is_mop(op);
    assign acc_base = accept & ~is_m;
    assign acc_m    = accept & is_m;

    // ---------------- base ALU ----------------
    logic [XLEN-1:0] op2, alu_val, alu_pc, jalr_tgt;
    logic [SH_W-1:0] shamt;
    logic            alu_jump, br_take, is_br;

    always_comb begin
        alu_val  = '0;
        alu_pc   = '0;
        alu_jump = 1'b0;
        br_take  = 1'b0;
        is_br    = 1'b0;
        jalr_tgt = in_rs1 + in_imm;
        case (op)
            OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI:
                op2 = in_imm;
            default:
                op2 = in_rs2;
        endcase
        shamt = op2[SH_W-1:0];
        if (op_known) begin
            case (op)
                OP_ADD, OP_ADDI:   alu_val = in_rs1 + op2;
                OP_SUB:            alu_val = in_rs1 - op2;
                OP_SLL, OP_SLLI:   alu_val = in_rs1 << shamt;
                OP_SLT, OP_SLTI:   alu_val = XLEN'($signed(in_rs1) < $signed(op2));
                OP_SLTU, OP_SLTIU: alu_val = XLEN'(in_rs1 < op2);
                OP_XOR, OP_XORI:   alu_val = in_rs1 ^ op2;
                OP_SRL, OP_SRLI:   alu_val = in_rs1 >> shamt;
                OP_SRA, OP_SRAI:   alu_val = $signed(in_rs1) >>> shamt;
                OP_OR, OP_ORI:     alu_val = in_rs1 | op2;
                OP_AND, OP_ANDI:   alu_val = in_rs1 & op2;
                OP_LUI:            alu_val = in_imm;
                OP_AUIPC:          alu_val = in_pc + in_imm;
                OP_JAL: begin
                    alu_val  = in_pc + XLEN'(4);
                    alu_jump = 1'b1;
                    alu_pc   = in_pc + in_imm;
                end
                OP_JALR: begin
                    alu_val  = in_pc + XLEN'(4);
                    alu_jump = 1'b1;
                    alu_pc   = {jalr_tgt[XLEN-1:1], 1'b0};
                end
                OP_BEQ:  begin is_br = 1'b1; br_take = (in_rs1 == in_rs2); end
                OP_BNE:  begin is_br = 1'b1; br_take = (in_rs1 != in_rs2); end
                OP_BLT:  begin is_br = 1'b1; br_take = ($signed(in_rs1) < $signed(in_rs2)); end
                OP_BGE:  begin is_br = 1'b1; br_take = ($signed(in_rs1) >= $signed(in_rs2)); end
                OP_BLTU: begin is_br = 1'b1; br_take = (in_rs1 < in_rs2); end
                OP_BGEU: begin is_br = 1'b1; br_take = (in_rs1 >= in_rs2); end
                default: alu_val = '0;
            endcase
            // Branches always resolve a next PC; the value field stays zero.
            if (is_br) begin
                alu_jump = br_take;
                alu_pc   = br_take ? (in_pc + in_imm) : (in_pc + XLEN'(4));
            end
        end
    end

    // ---------------- iterative M-op datapath ----------------
    logic            md_done, m_fin;
    logic [XLEN-1:0] md_result;
    mop_t            md_kind;

    assign md_kind = decode_mop(op);

    muldiv_iter #(.XLEN(XLEN)) u_iter (
        .clk    (clk),
        .rst    (rst),
        .en     (rdy),
        .clr    (clr),
        .start  (acc_m),
        .kind   (md_kind),
        .a      (in_rs1),
        .b      (in_rs2),
        .done   (md_done),
        .result (md_result)
    );

    assign m_fin = (state == S_RUN) & md_done;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = S_IDLE;
        end else if (rdy) begin
            case (state)
                S_IDLE:  if (acc_m) state_nxt = S_RUN;
                S_RUN:   if (md_done) state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // ---------------- broadcast register ----------------
    logic [ROB_POS_W-1:0] m_rob;

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid   <= 1'b0;
            out_rob_pos <= '0;
            out_val     <= '0;
            out_jump    <= 1'b0;
            out_pc      <= '0;
            m_rob       <= '0;
        end else if (clr) begin
            out_valid   <= 1'b0;
            out_rob_pos <= '0;
            out_val     <= '0;
            out_jump    <= 1'b0;
            out_pc      <= '0;
        end else if (rdy) begin
            // Base ops and M-op completion can never coincide: in_ready is low throughout RUN.
            out_valid <= acc_base | m_fin;
            if (acc_m)
                m_rob <= in_rob_pos;
            if (acc_base) begin
                out_rob_pos <= in_rob_pos;
                out_val     <= alu_val;
                out_jump    <= alu_jump;
                out_pc      <= alu_pc;
            end else if (m_fin) begin
                out_rob_pos <= m_rob;
                out_val     <= md_result;
                out_jump    <= 1'b0;
                out_pc      <= '0;
            end
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
module tb_alu_muldiv;
    import alu_muldiv_pkg::*;

    localparam int XLEN = 32;
    localparam int RW   = 5;
    localparam int OW   = 6;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            rdy = 1'b0;
    logic            clr = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [OW-1:0]   in_op = '0;
    logic [RW-1:0]   in_rob_pos = '0;
    logic [XLEN-1:0] in_rs1 = '0, in_rs2 = '0, in_imm = '0, in_pc = '0;
    logic            out_valid;
    logic [RW-1:0]   out_rob_pos;
    logic [XLEN-1:0] out_val;
    logic            out_jump;
    logic [XLEN-1:0] out_pc;

    alu_muldiv #(.XLEN(XLEN), .ROB_POS_W(RW), .OP_W(OW)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rob_pos(in_rob_pos),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_pc(in_pc),
        .out_valid(out_valid), .out_rob_pos(out_rob_pos), .out_val(out_val),
        .out_jump(out_jump), .out_pc(out_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          rob;
        logic [31:0] val;
        logic        jump;
        logic [31:0] pc;
        int          edge_n;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    int   cyc = 0;
    logic rdy_q = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   next_rob = 1;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rdy_q <= rdy;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, req);
        end
    endtask

    // Monitor: a broadcast following an enabled edge is new and is checked against the
    // scoreboard head; one following a frozen edge must still show the previous result.
    always @(negedge clk) begin
        if (out_valid) begin
            if (rdy_q) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 64'(sb.size()), 64'd1);
                end else begin
                    last_exp = sb.pop_front();
                    chk({last_exp.name, "_val"},  out_val,     last_exp.val);
                    chk({last_exp.name, "_jump"}, out_jump,    last_exp.jump);
                    chk({last_exp.name, "_pc"},   out_pc,      last_exp.pc);
                    chk({last_exp.name, "_rob"},  out_rob_pos, 64'(last_exp.rob));
                    chk({last_exp.name, "_edge"}, 64'(cyc),    64'(last_exp.edge_n));
                end
            end else begin
                chk({last_exp.name, "_hold_val"}, out_val,     last_exp.val);
                chk({last_exp.name, "_hold_rob"}, out_rob_pos, 64'(last_exp.rob));
            end
        end
    end

    // Called at a falling edge; the next rising edge is the accepting edge E.
    task automatic issue(input string nm, input logic [5:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [31:0] pc,
                         input logic [31:0] ev, input logic ej, input logic [31:0] ep,
                         input int lat, input bit push);
        exp_t e;
        in_valid   = 1'b1;
        in_op      = op;
        in_rs1     = a;
        in_rs2     = b;
        in_imm     = imm;
        in_pc      = pc;
        in_rob_pos = RW'(next_rob);
        if (push) begin
            e.name   = nm;
            e.rob    = next_rob & 31;
            e.val    = ev;
            e.jump   = ej;
            e.pc     = ep;
            e.edge_n = cyc + 1 + lat;
            sb.push_back(e);
        end
        next_rob++;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_idle"}, in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (errors=%0d checks=%0d)", errors, checks);
        $fatal(1);
    end

    initial begin
        int bad;
        int n;

        rst = 1'b0;
        rdy = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_val",   out_val,   0);
        chk("rst_pc",    out_pc,    0);
        chk("rst_ready", in_ready,  1);
        rst = 1'b1;
        @(negedge clk);

        // base ops, back to back
        issue("add_ovf", OP_ADD,   32'h7FFFFFFF, 32'h1, 0, 0, 32'h80000000, 0, 0, 0, 1);
        issue("sra",     OP_SRA,   32'h80000000, 32'h4, 0, 0, 32'hF8000000, 0, 0, 0, 1);
        issue("srli",    OP_SRLI,  32'h80000000, 32'hFFFF, 32'h24, 0, 32'h08000000, 0, 0, 0, 1);
        issue("sub",     OP_SUB,   32'h0, 32'h1, 0, 0, 32'hFFFFFFFF, 0, 0, 0, 1);
        issue("sltu",    OP_SLTU,  32'h1, 32'hFFFFFFFF, 0, 0, 32'h1, 0, 0, 0, 1);
        issue("slt",     OP_SLT,   32'h1, 32'hFFFFFFFF, 0, 0, 32'h0, 0, 0, 0, 1);
        issue("lui",     OP_LUI,   0, 0, 32'h12345000, 0, 32'h12345000, 0, 0, 0, 1);
        issue("auipc",   OP_AUIPC, 0, 0, 32'h2000, 32'h1000, 32'h3000, 0, 0, 0, 1);
        issue("blt",     OP_BLT,   32'hFFFFFFFF, 0, 32'h20, 32'h100, 0, 1, 32'h120, 0, 1);
        issue("bgeu",    OP_BGEU,  32'hFFFFFFFF, 0, 32'h20, 32'h100, 0, 1, 32'h120, 0, 1);
        issue("beq_nt",  OP_BEQ,   32'h1, 32'h2, 32'h20, 32'h100, 0, 0, 32'h104, 0, 1);
        issue("jal",     OP_JAL,   0, 0, 32'h40, 32'h100, 32'h104, 1, 32'h140, 0, 1);
        issue("jalr",    OP_JALR,  32'h201, 0, 0, 32'h300, 32'h304, 1, 32'h200, 0, 1);
        issue("unknown", 6'h3F,    32'h5, 32'h6, 32'h7, 32'h8, 0, 0, 0, 0, 1);

        // pending broadcast frozen by rdy=0
        issue("add_hold", OP_ADD, 32'h3, 32'h4, 0, 0, 32'h7, 0, 0, 0, 1);
        rdy = 1'b0;
        repeat (3) @(negedge clk);
        rdy = 1'b1;
        @(negedge clk);

        // MULH with busy window
        issue("mulh", OP_MULH, 32'h80000000, 32'h80000000, 0, 0, 32'h40000000, 0, 0, 32, 1);
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            if (in_ready !== 1'b0) bad++;
            @(negedge clk);
        end
        chk("mulh_busy_cycles", 64'(bad), 0);
        chk("mulh_ready_after", in_ready, 1);

        issue("mul",    OP_MUL,    32'h7, 32'hFFFFFFFD, 0, 0, 32'hFFFFFFEB, 0, 0, 32, 1); wait_idle("mul");
        issue("mulhu",  OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 32'hFFFFFFFE, 0, 0, 32, 1); wait_idle("mulhu");
        issue("mulhsu", OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 32'hFFFFFFFF, 0, 0, 32, 1); wait_idle("mulhsu");
        issue("div_dz",  OP_DIV,  32'h5, 32'h0, 0, 0, 32'hFFFFFFFF, 0, 0, 32, 1); wait_idle("div_dz");
        issue("divn_dz", OP_DIV,  32'hFFFFFFFB, 32'h0, 0, 0, 32'hFFFFFFFF, 0, 0, 32, 1); wait_idle("divn_dz");
        issue("remu_dz", OP_REMU, 32'h5, 32'h0, 0, 0, 32'h5, 0, 0, 32, 1); wait_idle("remu_dz");
        issue("rem_dz",  OP_REM,  32'hFFFFFFFB, 32'h0, 0, 0, 32'hFFFFFFFB, 0, 0, 32, 1); wait_idle("rem_dz");
        issue("div_ovf", OP_DIV,  32'h80000000, 32'hFFFFFFFF, 0, 0, 32'h80000000, 0, 0, 32, 1); wait_idle("div_ovf");
        issue("rem_ovf", OP_REM,  32'h80000000, 32'hFFFFFFFF, 0, 0, 32'h0, 0, 0, 32, 1); wait_idle("rem_ovf");
        issue("div_neg", OP_DIV,  32'hFFFFFFF9, 32'h2, 0, 0, 32'hFFFFFFFD, 0, 0, 32, 1); wait_idle("div_neg");
        issue("rem_neg", OP_REM,  32'hFFFFFFF9, 32'h2, 0, 0, 32'hFFFFFFFF, 0, 0, 32, 1); wait_idle("rem_neg");

        // DIVU with three frozen cycles mid-run
        issue("divu_stall", OP_DIVU, 32'd100, 32'd7, 0, 0, 32'd14, 0, 0, 35, 1);
        repeat (9) @(negedge clk);
        rdy = 1'b0;
        repeat (3) @(negedge clk);
        rdy = 1'b1;
        wait_idle("divu_stall");

        // clr at iteration 10 of MUL: no broadcast, outputs cleared, ready again
        issue("mul_clr", OP_MUL, 32'h3, 32'h5, 0, 0, 0, 0, 0, 32, 0);
        repeat (9) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_valid", out_valid, 0);
        chk("clr_val",   out_val,   0);
        chk("clr_ready", in_ready,  1);
        // an issue coinciding with clr is dropped
        clr = 1'b1;
        issue("add_clr_drop", OP_ADD, 32'h1, 32'h1, 0, 0, 0, 0, 0, 0, 0);
        clr = 1'b0;
        repeat (40) @(negedge clk);

        // reset mid-RUN discards the op; a fresh ADD then completes
        issue("add_pre", OP_ADD, 32'h55, 32'h0, 0, 0, 32'h55, 0, 0, 0, 1);
        issue("div_rst", OP_DIV, 32'd100, 32'd3, 0, 0, 0, 0, 0, 32, 0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("rstrun_valid", out_valid,   0);
        chk("rstrun_val",   out_val,     0);
        chk("rstrun_rob",   out_rob_pos, 0);
        chk("rstrun_ready", in_ready,    1);
        issue("add_fresh", OP_ADD, 32'h2, 32'h3, 0, 0, 32'h5, 0, 0, 0, 1);
        repeat (40) @(negedge clk);

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", 64'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width; legal values 32 and 64.
REQ-002 SHALL have parameter ROB_POS_W, default 5, ROB wrap-position width.
REQ-003 SHALL have parameter OP_W, default 6, opcode-enum width.
REQ-004 clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-low (0 = reset).
REQ-006 rdy  input  1  global enable; 0 freezes all state.
REQ-007 clr  input  1  pipeline flush from ROB misprediction.
REQ-008 in_valid  input  1  issue request from RS.
REQ-009 in_ready  output  1  unit can accept; combinational, high iff FSM is IDLE.
REQ-010 in_op  input  OP_W  operation enum.
REQ-011 in_rob_pos  input  ROB_POS_W  destination ROB tag.
REQ-012 in_rs1, in_rs2, in_imm, in_pc  input  XLEN each  operands, immediate, instruction PC.
REQ-013 out_valid  output  1  one-cycle result broadcast.
REQ-014 out_rob_pos  output  ROB_POS_W  tag of the broadcast result.
REQ-015 out_val  output  XLEN  result value.
REQ-016 out_jump  output  1  branch taken / jump.
REQ-017 out_pc  output  XLEN  resolved next PC for control-flow ops, else 0.

Function
REQ-018 Accept SHALL be in_valid & in_ready & rdy & rst & !clr, sampled at the rising edge.
REQ-019 Base ops (RV base ALU, branches, JAL, JALR, LUI, AUIPC) SHALL broadcast at the accepting edge; out_valid is high the following cycle only.
REQ-020 Shifts SHALL use in_rs2/in_imm bits [log2(XLEN)-1:0]; SRA/SRAI SHALL be arithmetic (sign-filling).
REQ-021 Branch taken SHALL give out_jump=1, out_pc=pc+imm; not taken SHALL give out_jump=0, out_pc=pc+4, out_val=0.
REQ-022 JAL/JALR SHALL give out_jump=1, out_val=pc+4; the JALR target SHALL be (rs1+imm) with bit 0 cleared.
REQ-023 Non-control ops SHALL drive out_jump=0 and out_pc=0; all arithmetic SHALL be modulo 2^XLEN.
REQ-024 M-ops (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) SHALL use a FSM with states IDLE and RUN: accepting edge IDLE->RUN, counter loaded with XLEN.
REQ-025 RUN SHALL perform one radix-2 iteration per rdy-high edge (shift-add multiply on magnitudes; restoring divide) and decrement the counter.
REQ-026 The edge that completes iteration XLEN SHALL register the result and return RUN->IDLE. Fixed latency: accept at edge E gives out_valid in the cycle after edge E+XLEN when rdy is constantly high.
REQ-027 The signed result sign SHALL be fixed after the magnitude loop: MULH is signed x signed, MULHSU is signed x unsigned, quotient sign is rs1^rs2, remainder sign is that of rs1.
REQ-028 Divide by zero SHALL give DIV/DIVU = all ones, REM/REMU = rs1, with the same fixed latency.
REQ-029 DIV of most-negative by -1 SHALL give most-negative; the matching REM SHALL give 0.
REQ-030 in_ready SHALL be 0 throughout RUN; no base op can overlap an M-op and no broadcast collision is possible.
REQ-031 rdy=0 SHALL hold FSM, counter, datapath and all outputs unchanged, including a pending out_valid.
REQ-032 clr=1 at an edge SHALL, regardless of rdy, abort any RUN (go to IDLE), drop any accept that cycle, and clear all outputs to 0.
REQ-033 An unknown opcode SHALL be accepted and broadcast with out_val=0, out_jump=0, out_pc=0.

Reset
REQ-034 rst=0 at an edge SHALL force IDLE, counter 0, and all outputs 0 (out_valid, out_rob_pos, out_val, out_jump, out_pc); in_ready is 1 the cycle after.
REQ-035 Reset SHALL take priority over clr, which SHALL take priority over rdy; reset mid-RUN discards the operation without a broadcast.

Structure
REQ-036 The OPENUM codes for the new M-ops and the XLEN-derived constants SHALL be added to the shared definition.v; no local opcode literals.
REQ-037 The iterative datapath (operand magnitudes, counter, shift registers, sign fix, special cases) SHALL be one sub-module, muldiv_iter, with start/done handshake; alu_muldiv holds the FSM, base ALU and broadcast register.

Verification
REQ-038 ADD rs1=0x7FFFFFFF rs2=1 -> next cycle out_valid=1, out_val=0x80000000, out_jump=0; SRA 0x80000000 by 4 -> 0xF8000000.
REQ-039 BLT rs1=-1 rs2=0, pc=0x100, imm=0x20 -> out_jump=1, out_pc=0x120; BGEU same operands -> out_jump=1; JALR rs1=0x201 imm=0 -> out_pc=0x200, out_val=pc+4.
REQ-040 MULH 0x80000000 x 0x80000000 -> out_val=0x40000000 exactly 32 edges after accept; in_ready=0 for those 32 cycles.
REQ-041 DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000; REM of the same -> 0.
REQ-042 DIVU 100/7 with rdy toggled low for 3 cycles mid-RUN -> out_val=14 on edge E+32+3, outputs stable while rdy=0.
REQ-043 clr at iteration 10 of MUL -> no out_valid, in_ready=1 next cycle; rst=0 mid-RUN -> all outputs 0, then a fresh ADD completes normally.
